cache_control: RTL and testbench
================================

# cache_control

Control FSM for the 2-way set-associative cache. It sequences a CPU request through tag compare, dirty-victim writeback and line allocation. It drives the dirty-bit, LRU and line-load strobes of the cache datapath and the physical-memory handshake. It also keeps saturating hit/miss counters for performance debug. It sits between the CPU-side mem_* interface and the pmem_* interface, alongside the cache datapath.

## Interface
Parameters:
- CNT_W, 16, width of hit_count / miss_count

Ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge
- rst, in, 1, reset; synchronous and active-high
- mem_read, in, 1, CPU read request; held until mem_resp
- mem_write, in, 1, CPU write request; held until mem_resp
- hit_0 / hit_1, in, 1 each, way 0 / way 1 valid tag match (datapath compare)
- dirty_0 / dirty_1, in, 1 each, dirty bit of way 0 / way 1 for the indexed set
- lru, in, 1, LRU way of the indexed set (0 = way 0 is victim)
- pmem_resp, in, 1, physical memory transfer complete
- cnt_clr, in, 1, clears both counters
- mem_resp, out, 1, one-cycle response to CPU
- pmem_read, out, 1, line fill request
- pmem_write, out, 1, line writeback request
- pmem_addr_sel, out, 1, 0 = CPU address, 1 = {victim tag, index}
- set_dirty, out, 1, mark hit way dirty (datapath selects the way by hit_1)
- clr_dirty, out, 1, clear dirty bit of the lru way
- load_line, out, 1, write the fetched line, tag and valid=1 into the lru way
- load_data, out, 1, write CPU write data into the hit way
- load_lru, out, 1, update LRU bit
- lru_data, out, 1, new LRU value (= ~hit way)
- hit_count / miss_count, out, CNT_W, saturating counters

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. On reset the FSM enters IDLE. Outputs are combinational decodes of state and inputs.
- IDLE:
  - All strobes are 0.
  - If mem_read or mem_write is 1, go to COMPARE.
- COMPARE: hit = hit_0 | hit_1.
  - Request dropped (mem_read = mem_write = 0): go to IDLE with no strobes.
  - Hit: mem_resp=1, load_lru=1, lru_data=~hit_1. A write also asserts set_dirty=1 and load_data=1. Go to IDLE.
  - Miss, victim dirty (lru ? dirty_1 : dirty_0): go to WRITEBACK.
  - Miss, victim clean: go to ALLOCATE.
  - Both mem_read and mem_write asserted: treated as a write.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, held until pmem_resp.
  - In the pmem_resp cycle: clr_dirty=1, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, held until pmem_resp.
  - In the pmem_resp cycle: load_line=1, set the refill flag, then go to COMPARE.
- Refill flag:
  - Set on ALLOCATE→COMPARE; cleared on entry to IDLE and on rst.
  - The hit that follows a refill is not counted as a hit.
- Counters:
  - hit_count increments on a COMPARE hit with refill=0.
  - miss_count increments on COMPARE→WRITEBACK or COMPARE→ALLOCATE.
  - Both saturate at 2^CNT_W−1 with no wrap.
  - cnt_clr zeroes both and takes priority over an increment in the same cycle.
- Once WRITEBACK or ALLOCATE is entered, the pmem transaction runs to completion even if the CPU drops its request. The final COMPARE then handles the drop.

## Timing
- Reset values: state=IDLE, refill=0, hit_count=miss_count=0. All outputs 0 in the cycle after rst is sampled.
- rst asserted mid-operation (any state): IDLE on the next edge; pmem_read and pmem_write drop immediately.
- Hit latency: request first high in IDLE at cycle N; COMPARE at N+1 with mem_resp=1; IDLE at N+2. The CPU deasserts its request in cycle N+2.
- Clean miss: COMPARE at N+1; ALLOCATE from N+2 until the pmem_resp cycle M; COMPARE at M+1 with mem_resp.
- Dirty miss: WRITEBACK from N+2 until pmem_resp at W; ALLOCATE from W+1 until pmem_resp at M; mem_resp at M+1.
- pmem_resp arriving in the same cycle that pmem_read/pmem_write is first asserted is legal and completes that phase.
- pmem_resp seen in IDLE or COMPARE is ignored.

## Test plan
- Read hit way 1 (hit_1=1, mem_read=1): mem_resp at N+1, load_lru=1, lru_data=0, no set_dirty; hit_count=1.
- Write hit way 0: at N+1, set_dirty=1, load_data=1, lru_data=1, mem_resp=1; dirty_load of way 0 follows; no pmem traffic.
- Clean miss, lru=0, pmem_resp after 5 cycles:
  - pmem_read high exactly 5 cycles, then load_line=1 for one cycle.
  - Re-COMPARE with hit gives mem_resp.
  - miss_count=1, hit_count=0.
- Dirty miss, lru=1, dirty_1=1:
  - pmem_write with pmem_addr_sel=1 until pmem_resp; clr_dirty pulse in that cycle.
  - Then pmem_read with pmem_addr_sel=0; final mem_resp.
  - pmem_read and pmem_write never high together.
- rst asserted during ALLOCATE: next cycle state=IDLE, pmem_read=0, counters=0. A fresh request afterwards behaves as a clean miss.
- Saturation with CNT_W=4: 20 read hits leave hit_count=15. cnt_clr coincident with a hit gives hit_count=0.

Source files
------------

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative cache.
// Sequences compare, writeback and allocate; keeps hit/miss counters.
module cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit_0,
  input  logic             hit_1,
  input  logic             dirty_0,
  input  logic             dirty_1,
  input  logic             lru,
  input  logic             pmem_resp,
  input  logic             cnt_clr,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             load_line,
  output logic             load_data,
  output logic             load_lru,
  output logic             lru_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_refill;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic w_req;
  logic w_hit;
  logic w_vdirty;
  logic w_hit_inc;
  logic w_miss_inc;

  assign w_req    = mem_read | mem_write;
  assign w_hit    = hit_0 | hit_1;
  assign w_vdirty = lru ? dirty_1 : dirty_0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Strobes are gated by rst so a pmem transfer drops in the reset cycle.
  always_comb begin
    w_next        = r_state;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    load_line     = 1'b0;
    load_data     = 1'b0;
    load_lru      = 1'b0;
    lru_data      = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) w_next = S_COMPARE;
        end
        S_COMPARE: begin
          if (!w_req) begin
            w_next = S_IDLE;
          end else if (w_hit) begin
            mem_resp  = 1'b1;
            load_lru  = 1'b1;
            lru_data  = ~hit_1;
            set_dirty = mem_write;
            load_data = mem_write;
            w_hit_inc = ~r_refill;
            w_next    = S_IDLE;
          end else begin
            w_miss_inc = 1'b1;
            w_next     = w_vdirty ? S_WRITEBACK
                                  : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) begin
            clr_dirty = 1'b1;
            w_next    = S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_line = 1'b1;
            w_next    = S_COMPARE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_refill <= 1'b0;
    else if (r_state == S_ALLOCATE && pmem_resp)
      r_refill <= 1'b1;
    else if (w_next == S_IDLE)
      r_refill <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc && r_hit_cnt != {CNT_W{1'b1}})
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_miss_inc && r_miss_cnt != {CNT_W{1'b1}})
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control.
// Outputs are packed into one vector and compared per cycle.
module tb_cache_control;

  localparam int CNT_W = 4;

  localparam logic [9:0] M_RESP = 10'h200;
  localparam logic [9:0] M_PRD  = 10'h100;
  localparam logic [9:0] M_PWR  = 10'h080;
  localparam logic [9:0] M_SEL  = 10'h040;
  localparam logic [9:0] M_SD   = 10'h020;
  localparam logic [9:0] M_CD   = 10'h010;
  localparam logic [9:0] M_LL   = 10'h008;
  localparam logic [9:0] M_LD   = 10'h004;
  localparam logic [9:0] M_LLRU = 10'h002;
  localparam logic [9:0] M_LDAT = 10'h001;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write;
  logic hit_0, hit_1, dirty_0, dirty_1, lru;
  logic pmem_resp, cnt_clr;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic set_dirty, clr_dirty, load_line, load_data;
  logic load_lru, lru_data;
  logic [CNT_W-1:0] hit_count, miss_count;
  logic [9:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign outs = {mem_resp, pmem_read, pmem_write,
                 pmem_addr_sel, set_dirty, clr_dirty,
                 load_line, load_data, load_lru, lru_data};

  cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .hit_0(hit_0), .hit_1(hit_1),
    .dirty_0(dirty_0), .dirty_1(dirty_1),
    .lru(lru), .pmem_resp(pmem_resp),
    .cnt_clr(cnt_clr),
    .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .load_line(load_line), .load_data(load_data),
    .load_lru(load_lru), .lru_data(lru_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0;
    hit_0 = 0; hit_1 = 0;
    dirty_0 = 0; dirty_1 = 0;
    lru = 0; pmem_resp = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL reset_outs: got %h exp %h", outs, 10'h0);
    end
    rst = 0;
    tick();
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 0 || miss_count !== 0) begin
      failures++;
      $display("FAIL reset_state: outs %h hc %0d mc %0d exp 0",
               outs, hit_count, miss_count);
    end
  endtask

  task automatic test_read_hit();
    mem_read = 1; hit_1 = 1;
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL rhit_idle: got %h exp %h", outs, 10'h0);
    end
    tick();
    #2;
    checks++;
    if (outs !== (M_RESP | M_LLRU)) begin
      failures++;
      $display("FAIL rhit_cmp: got %h exp %h", outs, M_RESP | M_LLRU);
    end
    tick();
    mem_read = 0; hit_1 = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 4'd1) begin
      failures++;
      $display("FAIL rhit_after: outs %h hc %0d exp 0/1",
               outs, hit_count);
    end
  endtask

  task automatic test_write_hit();
    mem_write = 1; hit_0 = 1;
    tick();
    #2;
    checks++;
    if (outs !== (M_RESP | M_SD | M_LD | M_LLRU | M_LDAT)) begin
      failures++;
      $display("FAIL whit_cmp: got %h exp %h", outs,
               M_RESP | M_SD | M_LD | M_LLRU | M_LDAT);
    end
    tick();
    mem_write = 0; hit_0 = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 4'd2) begin
      failures++;
      $display("FAIL whit_after: outs %h hc %0d exp 0/2",
               outs, hit_count);
    end
  endtask

  task automatic test_clean_miss();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    #2;
    checks++;
    if (hit_count !== 0 || miss_count !== 0) begin
      failures++;
      $display("FAIL cm_clr: hc %0d mc %0d exp 0/0",
               hit_count, miss_count);
    end
    mem_read = 1; lru = 0;
    tick();
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL cm_cmp: got %h exp %h", outs, 10'h0);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      pmem_resp = (i == 4);
      #2;
      checks++;
      if (outs !== (M_PRD | ((i == 4) ? M_LL : 10'h0))) begin
        failures++;
        $display("FAIL cm_alloc%0d: got %h exp %h", i, outs,
                 M_PRD | ((i == 4) ? M_LL : 10'h0));
      end
      tick();
    end
    pmem_resp = 0; hit_0 = 1;
    #2;
    checks++;
    if (outs !== (M_RESP | M_LLRU | M_LDAT) || miss_count !== 4'd1) begin
      failures++;
      $display("FAIL cm_recmp: outs %h mc %0d exp %h/1",
               outs, miss_count, M_RESP | M_LLRU | M_LDAT);
    end
    tick();
    mem_read = 0; hit_0 = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 0 || miss_count !== 4'd1) begin
      failures++;
      $display("FAIL cm_after: outs %h hc %0d mc %0d exp 0/0/1",
               outs, hit_count, miss_count);
    end
  endtask

  task automatic test_dirty_miss();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    mem_write = 1; lru = 1; dirty_1 = 1;
    tick();
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL dm_cmp: got %h exp %h", outs, 10'h0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      pmem_resp = (i == 2);
      #2;
      checks++;
      if (outs !== (M_PWR | M_SEL | ((i == 2) ? M_CD : 10'h0))) begin
        failures++;
        $display("FAIL dm_wb%0d: got %h exp %h", i, outs,
                 M_PWR | M_SEL | ((i == 2) ? M_CD : 10'h0));
      end
      tick();
    end
    dirty_1 = 0;
    for (int i = 0; i < 2; i++) begin
      pmem_resp = (i == 1);
      #2;
      checks++;
      if (outs !== (M_PRD | ((i == 1) ? M_LL : 10'h0))) begin
        failures++;
        $display("FAIL dm_alloc%0d: got %h exp %h", i, outs,
                 M_PRD | ((i == 1) ? M_LL : 10'h0));
      end
      tick();
    end
    pmem_resp = 0; hit_1 = 1;
    #2;
    checks++;
    if (outs !== (M_RESP | M_SD | M_LD | M_LLRU) || miss_count !== 4'd1) begin
      failures++;
      $display("FAIL dm_recmp: outs %h mc %0d exp %h/1",
               outs, miss_count, M_RESP | M_SD | M_LD | M_LLRU);
    end
    tick();
    mem_write = 0; hit_1 = 0; lru = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 0) begin
      failures++;
      $display("FAIL dm_after: outs %h hc %0d exp 0/0",
               outs, hit_count);
    end
  endtask

  task automatic test_rst_mid();
    mem_read = 1; lru = 0;
    tick();
    tick();
    #2;
    checks++;
    if (outs !== M_PRD) begin
      failures++;
      $display("FAIL rm_alloc: got %h exp %h", outs, M_PRD);
    end
    rst = 1;
    #1;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL rm_drop: got %h exp %h", outs, 10'h0);
    end
    tick();
    rst = 0; mem_read = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || hit_count !== 0 || miss_count !== 0) begin
      failures++;
      $display("FAIL rm_idle: outs %h hc %0d mc %0d exp 0",
               outs, hit_count, miss_count);
    end
    mem_read = 1;
    tick();
    tick();
    pmem_resp = 1;
    #2;
    checks++;
    if (outs !== (M_PRD | M_LL)) begin
      failures++;
      $display("FAIL rm_fast: got %h exp %h", outs, M_PRD | M_LL);
    end
    tick();
    pmem_resp = 0; hit_0 = 1;
    #2;
    checks++;
    if (outs !== (M_RESP | M_LLRU | M_LDAT) || miss_count !== 4'd1) begin
      failures++;
      $display("FAIL rm_recmp: outs %h mc %0d exp %h/1",
               outs, miss_count, M_RESP | M_LLRU | M_LDAT);
    end
    tick();
    mem_read = 0; hit_0 = 0;
    #2;
    checks++;
    if (hit_count !== 0) begin
      failures++;
      $display("FAIL rm_refill: hc %0d exp 0", hit_count);
    end
  endtask

  task automatic test_drop_ignore();
    pmem_resp = 1;
    tick();
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL ig_idle: got %h exp %h", outs, 10'h0);
    end
    mem_read = 1;
    tick();
    mem_read = 0;
    #2;
    checks++;
    if (outs !== 10'h0) begin
      failures++;
      $display("FAIL ig_drop: got %h exp %h", outs, 10'h0);
    end
    tick();
    pmem_resp = 0;
    #2;
    checks++;
    if (outs !== 10'h0 || miss_count !== 4'd1) begin
      failures++;
      $display("FAIL ig_after: outs %h mc %0d exp 0/1",
               outs, miss_count);
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    for (int i = 0; i < 20; i++) begin
      mem_read = 1; hit_1 = 1;
      tick();
      tick();
      mem_read = 0; hit_1 = 0;
      tick();
    end
    #2;
    checks++;
    if (hit_count !== 4'd15 || miss_count !== 0) begin
      failures++;
      $display("FAIL sat: hc %0d mc %0d exp 15/0",
               hit_count, miss_count);
    end
    mem_read = 1; hit_1 = 1;
    tick();
    cnt_clr = 1;
    #2;
    checks++;
    if (outs !== (M_RESP | M_LLRU)) begin
      failures++;
      $display("FAIL clr_hit: got %h exp %h", outs, M_RESP | M_LLRU);
    end
    tick();
    cnt_clr = 0; mem_read = 0; hit_1 = 0;
    #2;
    checks++;
    if (hit_count !== 0) begin
      failures++;
      $display("FAIL clr_prio: hc %0d exp 0", hit_count);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_rst_mid();
    test_drop_ignore();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
